// File: rtl/multi_ch_phase_accum_pkg.sv
// ============================================================================
// multi_ch_phase_accum_pkg : shared widths and helpers for the DDS phase block
// Revision 1.0
// ============================================================================
`default_nettype none

package multi_ch_phase_accum_pkg;

   localparam int DEF_NCH        = 4;
   localparam int DEF_INC_BITS   = 32;
   localparam int DEF_COUNT_BITS = 32;
   localparam int DEF_OUT_BITS   = 16;
   localparam int DEF_OUT_BUS    = 16;

   // A single channel still needs a one-bit select port.
   function automatic int ch_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_ch_phase_accum_phase_snapshot_cdc.sv
// ============================================================================
// phase_snapshot_cdc : coherent multi-bit snapshot transfer via toggle req/ack
// Revision 1.0
// ============================================================================
`default_nettype none

module phase_snapshot_cdc #(
   parameter int WIDTH = 64
) (
   input  logic             clk_a_i,
   input  logic             rst_a_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             clk_b_i,
   input  logic             rst_b_n_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic             req_q, req_d;
   logic [WIDTH-1:0] snap_q, snap_d;
   logic [1:0]       ack_sync_q;
   logic             idle_a;

   logic [1:0]       req_sync_q;
   logic             ack_q, ack_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic             valid_q, valid_d;
   logic             toggle_b;

   // The snapshot only moves once the far side has acknowledged the last one.
   always_comb begin
      idle_a = (ack_sync_q[1] == req_q);
      req_d  = req_q;
      snap_d = snap_q;
      if (idle_a) begin
         req_d  = ~req_q;
         snap_d = data_i;
      end
   end

   always_ff @(posedge clk_a_i or negedge rst_a_n_i) begin
      if (!rst_a_n_i) begin
         req_q      <= 1'b0;
         snap_q     <= '0;
         ack_sync_q <= '0;
      end else begin
         req_q      <= req_d;
         snap_q     <= snap_d;
         ack_sync_q <= {ack_sync_q[0], ack_q};
      end
   end

   always_comb begin
      toggle_b = (req_sync_q[1] != ack_q);
      ack_d    = ack_q;
      cap_d    = cap_q;
      valid_d  = 1'b0;
      if (toggle_b) begin
         ack_d   = ~ack_q;
         cap_d   = snap_q;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_b_i or negedge rst_b_n_i) begin
      if (!rst_b_n_i) begin
         req_sync_q <= '0;
         ack_q      <= 1'b0;
         cap_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         req_sync_q <= {req_sync_q[0], req_q};
         ack_q      <= ack_d;
         cap_q      <= cap_d;
         valid_q    <= valid_d;
      end
   end

   assign data_o  = cap_q;
   assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/multi_ch_phase_accum.sv
// ============================================================================
// multi_ch_phase_accum : N-channel DDS phase generator with atomic commit
// Revision 1.0
// ============================================================================
`default_nettype none

module multi_ch_phase_accum
   import multi_ch_phase_accum_pkg::*;
#(
   parameter int NCH        = DEF_NCH,
   parameter int INC_BITS   = DEF_INC_BITS,
   parameter int COUNT_BITS = DEF_COUNT_BITS,
   parameter int OUT_BITS   = DEF_OUT_BITS,
   parameter int OUT_BUS    = DEF_OUT_BUS,
   parameter int CH_BITS    = ch_bits(NCH)
) (
   input  logic                   count_clk,
   input  logic                   rst,
   input  logic                   out_clk,
   input  logic                   sync_i,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [CH_BITS-1:0]     cfg_ch,
   input  logic [INC_BITS-1:0]    cfg_inc,
   input  logic [COUNT_BITS-1:0]  cfg_off,
   input  logic                   cfg_commit,
   output logic                   cfg_err,
   output logic [NCH*OUT_BUS-1:0] count_out,
   output logic                   out_valid
);

   localparam logic [CH_BITS:0] NCH_W = (CH_BITS+1)'(NCH);

   logic [1:0] rst_cnt_sync_q;
   logic [1:0] rst_out_sync_q;
   logic       rst_cnt_n;
   logic       rst_out_n;

   always_ff @(posedge count_clk or negedge rst) begin
      if (!rst) rst_cnt_sync_q <= '0;
      else      rst_cnt_sync_q <= {rst_cnt_sync_q[0], 1'b1};
   end

   always_ff @(posedge out_clk or negedge rst) begin
      if (!rst) rst_out_sync_q <= '0;
      else      rst_out_sync_q <= {rst_out_sync_q[0], 1'b1};
   end

   assign rst_cnt_n = rst_cnt_sync_q[1];
   assign rst_out_n = rst_out_sync_q[1];

   logic [INC_BITS-1:0]   shadow_inc_q [NCH];
   logic [INC_BITS-1:0]   shadow_inc_d [NCH];
   logic [COUNT_BITS-1:0] shadow_off_q [NCH];
   logic [COUNT_BITS-1:0] shadow_off_d [NCH];
   logic [INC_BITS-1:0]   active_inc_q [NCH];
   logic [INC_BITS-1:0]   active_inc_d [NCH];
   logic [COUNT_BITS-1:0] active_off_q [NCH];
   logic [COUNT_BITS-1:0] active_off_d [NCH];
   logic [COUNT_BITS-1:0] acc_q        [NCH];
   logic [COUNT_BITS-1:0] acc_d        [NCH];
   logic [COUNT_BITS-1:0] off_sum      [NCH];
   logic [OUT_BITS-1:0]   phase_q      [NCH];
   logic [OUT_BITS-1:0]   phase_d      [NCH];
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;
   logic                  wr_en;
   logic                  ch_legal;

   // Commit reads the next-state shadows so a same-cycle write is included.
   always_comb begin
      ready_d  = 1'b1;
      err_d    = err_q;
      wr_en    = cfg_valid && ready_q;
      ch_legal = ({1'b0, cfg_ch} < NCH_W);
      if (wr_en && !ch_legal) err_d = 1'b1;
      for (int k = 0; k < NCH; k++) begin
         shadow_inc_d[k] = shadow_inc_q[k];
         shadow_off_d[k] = shadow_off_q[k];
         if (wr_en && (cfg_ch == CH_BITS'(k))) begin
            shadow_inc_d[k] = cfg_inc;
            shadow_off_d[k] = cfg_off;
         end
         active_inc_d[k] = cfg_commit ? shadow_inc_d[k] : active_inc_q[k];
         active_off_d[k] = cfg_commit ? shadow_off_d[k] : active_off_q[k];
         acc_d[k]        = sync_i ? '0 : acc_q[k] + COUNT_BITS'(active_inc_q[k]);
         off_sum[k]      = acc_q[k] + active_off_q[k];
         phase_d[k]      = off_sum[k][COUNT_BITS-1 -: OUT_BITS];
      end
   end

   always_ff @(posedge count_clk or negedge rst_cnt_n) begin
      if (!rst_cnt_n) begin
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            shadow_inc_q[k] <= '0;
            shadow_off_q[k] <= '0;
            active_inc_q[k] <= '0;
            active_off_q[k] <= '0;
            acc_q[k]        <= '0;
            phase_q[k]      <= '0;
         end
      end else begin
         ready_q <= ready_d;
         err_q   <= err_d;
         for (int k = 0; k < NCH; k++) begin
            shadow_inc_q[k] <= shadow_inc_d[k];
            shadow_off_q[k] <= shadow_off_d[k];
            active_inc_q[k] <= active_inc_d[k];
            active_off_q[k] <= active_off_d[k];
            acc_q[k]        <= acc_d[k];
            phase_q[k]      <= phase_d[k];
         end
      end
   end

   assign cfg_ready = ready_q;
   assign cfg_err   = err_q;

   logic [NCH*OUT_BITS-1:0] phase_flat;
   logic [NCH*OUT_BITS-1:0] cap_flat;

   for (genvar k = 0; k < NCH; k++) begin : g_pack
      assign phase_flat[k*OUT_BITS +: OUT_BITS] = phase_q[k];
   end

   phase_snapshot_cdc #(
      .WIDTH (NCH*OUT_BITS)
   ) u_cdc (
      .clk_a_i   (count_clk),
      .rst_a_n_i (rst_cnt_n),
      .data_i    (phase_flat),
      .clk_b_i   (out_clk),
      .rst_b_n_i (rst_out_n),
      .data_o    (cap_flat),
      .valid_o   (out_valid)
   );

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      assign count_out[lane_lo(k, OUT_BUS) +: OUT_BUS] =
         OUT_BUS'(cap_flat[k*OUT_BITS +: OUT_BITS]);
   end

endmodule

`default_nettype wire
